// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: op codes, forward selects, FSM states.
package ex_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_MUL  = 3'd4;
    localparam logic [2:0] OP_ADDI = 3'd5;

    localparam logic [1:0] FWD_ID  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        StIdle,
        StBusy
    } ex_state_e;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial product per step, low XLEN bits kept.
module mul_iter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             step_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    output logic             last_o,
    output logic [XLEN-1:0]  acc_next_o
);

    logic [XLEN-1:0]  mcand_q;
    logic [XLEN-1:0]  mplier_q;
    logic [XLEN-1:0]  acc_q;
    logic [CNT_W-1:0] cnt_q;

    // Accumulator value after the current step; the top samples it on the final step.
    always_comb begin
        acc_next_o = acc_q + (mplier_q[0] ? mcand_q : '0);
        last_o     = (cnt_q == CNT_W'(XLEN - 1));
    end

    // Load operands on start, advance one bit per step.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (start_i) begin
            mcand_q  <= a_i;
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (step_i) begin
            acc_q    <= acc_next_o;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative MUL and EX/MEM output bank.
module ex_stage import ex_pkg::*; #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             all_stall_i,
    input  logic             valid_i,
    input  logic [31:0]      inst_i,
    input  logic [2:0]       Op_i,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    input  logic [XLEN-1:0]  imm_i,
    input  logic [4:0]       rsd_i,
    input  logic [1:0]       fwd_a_i,
    input  logic [1:0]       fwd_b_i,
    input  logic [XLEN-1:0]  mem_fwd_data_i,
    input  logic [XLEN-1:0]  wb_fwd_data_i,
    output logic [31:0]      inst_o,
    output logic [XLEN-1:0]  alu_result_o,
    output logic [XLEN-1:0]  rs2_data_o,
    output logic [4:0]       rsd_o,
    output logic             valid_o,
    output logic             mul_busy_o
);

    ex_state_e       state_q, state_d;
    logic [XLEN-1:0] op_a, op_b, alu_res;

    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [4:0]      rsd_q, rsd_d;
    logic            valid_q, valid_d;

    // Instruction context held while the multiply iterates.
    logic [31:0]     lat_inst_q, lat_inst_d;
    logic [XLEN-1:0] lat_b_q, lat_b_d;
    logic [4:0]      lat_rsd_q, lat_rsd_d;

    logic            mul_start, mul_step, mul_last;
    logic [XLEN-1:0] mul_acc_next;

    // Forward muxes; 11 falls back to the ID/EX value.
    always_comb begin
        case (fwd_a_i)
            FWD_WB:  op_a = wb_fwd_data_i;
            FWD_MEM: op_a = mem_fwd_data_i;
            default: op_a = rs1_data_i;
        endcase
        case (fwd_b_i)
            FWD_WB:  op_b = wb_fwd_data_i;
            FWD_MEM: op_b = mem_fwd_data_i;
            default: op_b = rs2_data_i;
        endcase
    end

    // Single-cycle ALU; MUL and reserved codes yield 0 here.
    always_comb begin
        case (Op_i)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_ADDI: alu_res = op_a + imm_i;
            default: alu_res = '0;
        endcase
    end

    // FSM next state, output bank next values and multiplier handshake.
    always_comb begin
        state_d    = state_q;
        inst_d     = inst_q;
        res_d      = res_q;
        b_d        = b_q;
        rsd_d      = rsd_q;
        valid_d    = valid_q;
        lat_inst_d = lat_inst_q;
        lat_b_d    = lat_b_q;
        lat_rsd_d  = lat_rsd_q;
        mul_start  = 1'b0;
        mul_step   = 1'b0;
        mul_busy_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (valid_i && (Op_i == OP_MUL)) begin
                    mul_busy_o = 1'b1;
                    mul_start  = !all_stall_i;
                    lat_inst_d = inst_i;
                    lat_b_d    = op_b;
                    lat_rsd_d  = rsd_i;
                    valid_d    = 1'b0;
                    state_d    = StBusy;
                end else begin
                    inst_d  = inst_i;
                    res_d   = alu_res;
                    b_d     = op_b;
                    rsd_d   = rsd_i;
                    valid_d = valid_i;
                end
            end
            StBusy: begin
                mul_busy_o = !mul_last;
                mul_step   = !all_stall_i;
                valid_d    = 1'b0;
                if (mul_last) begin
                    inst_d  = lat_inst_q;
                    res_d   = mul_acc_next;
                    b_d     = lat_b_q;
                    rsd_d   = lat_rsd_q;
                    valid_d = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output bank; a global stall freezes everything.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            inst_q     <= '0;
            res_q      <= '0;
            b_q        <= '0;
            rsd_q      <= '0;
            valid_q    <= 1'b0;
            lat_inst_q <= '0;
            lat_b_q    <= '0;
            lat_rsd_q  <= '0;
        end else if (!all_stall_i) begin
            state_q    <= state_d;
            inst_q     <= inst_d;
            res_q      <= res_d;
            b_q        <= b_d;
            rsd_q      <= rsd_d;
            valid_q    <= valid_d;
            lat_inst_q <= lat_inst_d;
            lat_b_q    <= lat_b_d;
            lat_rsd_q  <= lat_rsd_d;
        end
    end

    mul_iter #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_mul_iter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (mul_start),
        .step_i     (mul_step),
        .a_i        (op_a),
        .b_i        (op_b),
        .last_o     (mul_last),
        .acc_next_o (mul_acc_next)
    );

    assign inst_o       = inst_q;
    assign alu_result_o = res_q;
    assign rs2_data_o   = b_q;
    assign rsd_o        = rsd_q;
    assign valid_o      = valid_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: ALU ops, forwarding, MUL timing, stall and reset.
module tb_ex_stage;
    import ex_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        all_stall_i;
    logic        valid_i;
    logic [31:0] inst_i;
    logic [2:0]  Op_i;
    logic [31:0] rs1_data_i, rs2_data_i, imm_i;
    logic [4:0]  rsd_i;
    logic [1:0]  fwd_a_i, fwd_b_i;
    logic [31:0] mem_fwd_data_i, wb_fwd_data_i;
    logic [31:0] inst_o, alu_result_o, rs2_data_o;
    logic [4:0]  rsd_o;
    logic        valid_o, mul_busy_o;

    int errors = 0;
    int checks = 0;

    ex_stage #(
        .XLEN  (32),
        .CNT_W (5)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .all_stall_i    (all_stall_i),
        .valid_i        (valid_i),
        .inst_i         (inst_i),
        .Op_i           (Op_i),
        .rs1_data_i     (rs1_data_i),
        .rs2_data_i     (rs2_data_i),
        .imm_i          (imm_i),
        .rsd_i          (rsd_i),
        .fwd_a_i        (fwd_a_i),
        .fwd_b_i        (fwd_b_i),
        .mem_fwd_data_i (mem_fwd_data_i),
        .wb_fwd_data_i  (wb_fwd_data_i),
        .inst_o         (inst_o),
        .alu_result_o   (alu_result_o),
        .rs2_data_o     (rs2_data_o),
        .rsd_o          (rsd_o),
        .valid_o        (valid_o),
        .mul_busy_o     (mul_busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Present one ALU op in the current cycle, clock it, check the bank.
    task automatic alu_op(input string tag, input logic [2:0] op, input logic [1:0] fa,
                          input logic [1:0] fb, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic [31:0] expv,
                          input logic [31:0] exp_b);
        valid_i = 1'b1; Op_i = op; fwd_a_i = fa; fwd_b_i = fb;
        rs1_data_i = a; rs2_data_i = b; imm_i = imm;
        inst_i = {24'hA5C3E1, 5'd0, op}; rsd_i = 5'd9;
        #1;
        check1({tag, " busy"}, mul_busy_o, 1'b0);
        tick();
        check({tag, " result"}, alu_result_o, expv);
        check1({tag, " valid"}, valid_o, 1'b1);
        check({tag, " rs2"}, rs2_data_o, exp_b);
        check({tag, " inst"}, inst_o, {24'hA5C3E1, 5'd0, op});
        check({tag, " rsd"}, 32'(rsd_o), 32'd9);
    endtask

    // MUL presented in cycle 0; optional stall window of stall_len cycles from stall_at.
    task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv, input int stall_at, input int stall_len);
        int steps;
        valid_i = 1'b1; Op_i = OP_MUL; fwd_a_i = FWD_ID; fwd_b_i = FWD_ID;
        rs1_data_i = a; rs2_data_i = b; inst_i = 32'h02B50533; rsd_i = 5'd10;
        #1;
        check1({tag, " busy c0"}, mul_busy_o, 1'b1);
        tick();
        // Junk on ID/EX while busy must be ignored.
        Op_i = OP_ADD; rs1_data_i = 32'h0000DEAD; rs2_data_i = 32'h0000BEEF;
        inst_i = 32'h0; rsd_i = 5'd3;
        steps = 0;
        for (int c = 1; c <= 32 + stall_len; c++) begin
            all_stall_i = (c >= stall_at) && (c < stall_at + stall_len);
            #1;
            check1({tag, " valid low"}, valid_o, 1'b0);
            check1({tag, " busy"}, mul_busy_o, steps != 31);
            if (!all_stall_i) steps++;
            tick();
        end
        all_stall_i = 1'b0;
        valid_i = 1'b0;
        #1;
        check1({tag, " busy done"}, mul_busy_o, 1'b0);
        check1({tag, " valid"}, valid_o, 1'b1);
        check({tag, " result"}, alu_result_o, expv);
        check({tag, " rs2"}, rs2_data_o, b);
        check({tag, " inst"}, inst_o, 32'h02B50533);
        check({tag, " rsd"}, 32'(rsd_o), 32'd10);
        tick();
        check1({tag, " single pulse"}, valid_o, 1'b0);
    endtask

    initial begin
        logic saw_valid;
        rst_i = 1'b1; all_stall_i = 1'b0; valid_i = 1'b0; inst_i = '0; Op_i = '0;
        rs1_data_i = '0; rs2_data_i = '0; imm_i = '0; rsd_i = '0;
        fwd_a_i = '0; fwd_b_i = '0; mem_fwd_data_i = '0; wb_fwd_data_i = '0;
        #1;
        check1("reset valid", valid_o, 1'b0);
        check("reset result", alu_result_o, 32'd0);
        check("reset inst", inst_o, 32'd0);
        check1("reset busy", mul_busy_o, 1'b0);
        tick();
        tick();
        rst_i = 1'b0;

        mem_fwd_data_i = 32'd5;
        wb_fwd_data_i  = 32'h00000F0F;
        alu_op("add fwd mem", OP_ADD, FWD_MEM, FWD_ID, 32'd123, 32'hFFFFFFFF, 32'd0,
               32'd4, 32'hFFFFFFFF);
        alu_op("sub", OP_SUB, FWD_ID, FWD_ID, 32'd0, 32'd1, 32'd0,
               32'hFFFFFFFF, 32'd1);
        alu_op("and fwd wb", OP_AND, FWD_ID, FWD_WB, 32'h000000FF, 32'h12345678, 32'd0,
               32'h0000000F, 32'h00000F0F);
        alu_op("or fwd 11", OP_OR, 2'b11, 2'b11, 32'hF0000000, 32'h0000000A, 32'd0,
               32'hF000000A, 32'h0000000A);
        alu_op("addi", OP_ADDI, FWD_ID, FWD_ID, 32'd10, 32'd99, 32'hFFFFFFFD,
               32'd7, 32'd99);
        alu_op("op7", 3'd7, FWD_ID, FWD_ID, 32'd10, 32'd20, 32'd0, 32'd0, 32'd20);

        // Stall holds the bank even with a new op presented.
        all_stall_i = 1'b1;
        valid_i = 1'b1; Op_i = OP_ADD; rs1_data_i = 32'd1; rs2_data_i = 32'd1;
        tick();
        check("stall alu result", alu_result_o, 32'd0);
        check1("stall alu valid", valid_o, 1'b1);
        all_stall_i = 1'b0;
        valid_i = 1'b0;
        tick();
        check1("bubble valid", valid_o, 1'b0);

        do_mul("mul 7x6", 32'd7, 32'd6, 32'd42, 100, 0);
        do_mul("mul ffff*2", 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 100, 0);
        do_mul("mul wrap", 32'h00010000, 32'h00010000, 32'd0, 100, 0);
        do_mul("mul stall", 32'd12345, 32'd1000, 32'd12345000, 10, 5);

        // Reset in cycle 10 of a multiply discards it.
        valid_i = 1'b1; Op_i = OP_MUL; fwd_a_i = FWD_ID; fwd_b_i = FWD_ID;
        rs1_data_i = 32'd7; rs2_data_i = 32'd6; inst_i = 32'h02B50533; rsd_i = 5'd10;
        tick();
        valid_i = 1'b0;
        repeat (9) tick();
        check1("pre-reset busy", mul_busy_o, 1'b1);
        rst_i = 1'b1;
        #1;
        check1("mid reset busy", mul_busy_o, 1'b0);
        check1("mid reset valid", valid_o, 1'b0);
        check("mid reset result", alu_result_o, 32'd0);
        check("mid reset rs2", rs2_data_o, 32'd0);
        check("mid reset inst", inst_o, 32'd0);
        check("mid reset rsd", 32'(rsd_o), 32'd0);
        tick();
        rst_i = 1'b0;
        saw_valid = 1'b0;
        repeat (40) begin
            tick();
            if (valid_o) saw_valid = 1'b1;
        end
        check1("no valid after reset", saw_valid, 1'b0);
        alu_op("add after reset", OP_ADD, FWD_ID, FWD_ID, 32'd2, 32'd3, 32'd0,
               32'd5, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
